// File: rtl/color_num_select.sv
// color_num_select: synchronised, debounced up/down buttons driving a saturating colour count
module color_num_select #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int MIN_COLORS      = 3,
  parameter int MAX_COLORS      = 8,
  parameter int RESET_COLORS    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       game_active,
  output logic [3:0] COLOR_NUM,
  output logic       changed
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] L_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] L_MIN = 4'(MIN_COLORS);
  localparam logic [3:0] L_MAX = 4'(MAX_COLORS);
  localparam logic [3:0] L_RST = 4'(RESET_COLORS);
  typedef enum logic [1:0] {IDLE, ARMING, PRESSED, RELEASING} state_t;
  logic [1:0]    r_meta, r_sync, r_evt;
  state_t        r_state [2];
  logic [CW-1:0] r_cnt [2];
  logic          w_inc, w_dec;
  assign w_inc = r_evt[0] & ~r_evt[1] & ~game_active & (COLOR_NUM < L_MAX);
  assign w_dec = r_evt[1] & ~r_evt[0] & ~game_active & (COLOR_NUM > L_MIN);
  // two-flop synchroniser for both raw buttons (bit 0 = up, bit 1 = down)
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= {btn_down, btn_up};
      r_sync <= r_meta;
    end
  // per-button debounce FSM; r_evt pulses once when a press is accepted
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= '{IDLE, IDLE};
      r_cnt   <= '{default: '0};
      r_evt   <= '0;
    end else begin
      r_evt <= '0;
      for (int i = 0; i < 2; i++)
        case (r_state[i])
          IDLE:
            if (r_sync[i]) begin
              r_state[i] <= ARMING;
              r_cnt[i]   <= '0;
            end
          ARMING:
            if (!r_sync[i]) r_state[i] <= IDLE;
            else if (r_cnt[i] == L_LAST) begin
              r_state[i] <= PRESSED;
              r_evt[i]   <= 1'b1;
            end else r_cnt[i] <= r_cnt[i] + 1'b1;
          PRESSED:
            if (!r_sync[i]) begin
              r_state[i] <= RELEASING;
              r_cnt[i]   <= '0;
            end
          default:
            if (r_sync[i]) r_state[i] <= PRESSED;
            else if (r_cnt[i] == L_LAST) r_state[i] <= IDLE;
            else r_cnt[i] <= r_cnt[i] + 1'b1;
        endcase
    end
  // saturating count; same-cycle up+down events cancel, events during a game are dropped
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      COLOR_NUM <= L_RST;
      changed   <= 1'b0;
    end else begin
      changed   <= w_inc | w_dec;
      COLOR_NUM <= w_inc ? COLOR_NUM + 1'b1 : w_dec ? COLOR_NUM - 1'b1 : COLOR_NUM;
    end
endmodule

// File: tb/tb_color_num_select.sv
// tb_color_num_select: randomized scoreboard bench for the colour count selector
module tb_color_num_select;
  localparam int D = 4, MINC = 3, MAXC = 8, RSTC = 4;
  logic       clk = 1'b0, rst = 1'b1, btn_up = 1'b0, btn_down = 1'b0, game_active = 1'b0;
  logic [3:0] COLOR_NUM;
  logic       changed;
  int n_tests = 0, n_fail = 0;
  int model = RSTC;
  int exp_q[$];
  int mon_e;

  color_num_select #(.DEBOUNCE_CYCLES(D), .MIN_COLORS(MINC), .MAX_COLORS(MAXC),
                     .RESET_COLORS(RSTC)) dut (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down),
    .game_active(game_active), .COLOR_NUM(COLOR_NUM), .changed(changed));

  always #5 clk = ~clk;

  always @(negedge clk)
    if (!rst && changed) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_changed: COLOR_NUM=%0d while no change was expected", COLOR_NUM);
      end else begin
        mon_e = exp_q.pop_front();
        if (COLOR_NUM !== 4'(mon_e)) begin
          n_fail++;
          $display("FAIL changed_value: COLOR_NUM=%0d, expected %0d", COLOR_NUM, mon_e);
        end
      end
    end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_idle(input string name);
    check({name, "_pending"}, exp_q.size(), 0);
    check({name, "_count"}, int'(COLOR_NUM), model);
    exp_q.delete();
  endtask

  function automatic void expect_step(input int dir);
    if (game_active) return;
    if (model + dir >= MINC && model + dir <= MAXC) begin
      model += dir;
      exp_q.push_back(model);
    end
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    model = RSTC;
    exp_q.delete();
    tick(1);
    check("reset_count", int'(COLOR_NUM), RSTC);
    check("reset_changed", int'(changed), 0);
  endtask

  task automatic set_btn(input bit up, input bit v);
    if (up) btn_up = v;
    else btn_down = v;
  endtask

  task automatic single_press(input bit up, input int hold, input bit bounce);
    expect_step(up ? 1 : -1);
    if (bounce)
      repeat ($urandom_range(1, 3)) begin
        set_btn(up, 1'b1);
        tick($urandom_range(1, 3));
        set_btn(up, 1'b0);
        tick($urandom_range(1, 3));
      end
    set_btn(up, 1'b1);
    tick(hold);
    set_btn(up, 1'b0);
    if (bounce)
      repeat ($urandom_range(1, 3)) begin
        tick($urandom_range(1, 3));
        set_btn(up, 1'b1);
        tick($urandom_range(1, 3));
        set_btn(up, 1'b0);
      end
    tick(14);
  endtask

  task automatic both_press(input bit stagger, input bit up_first);
    if (stagger) begin
      expect_step(up_first ? 1 : -1);
      expect_step(up_first ? -1 : 1);
      set_btn(up_first, 1'b1);
      tick(1);
      set_btn(!up_first, 1'b1);
    end else begin
      btn_up = 1'b1;
      btn_down = 1'b1;
    end
    tick(14);
    btn_up = 1'b0;
    btn_down = 1'b0;
    tick(14);
  endtask

  initial begin
    int kind;
    do_reset();
    single_press(1'b1, 20, 1'b0);
    check_idle("hold_up");
    do_reset();
    repeat (3) begin
      btn_up = 1'b1;
      tick(2);
      btn_up = 1'b0;
      tick(2);
    end
    tick(14);
    check_idle("bounce");
    do_reset();
    for (int i = 0; i < 5; i++) begin
      single_press(1'b1, 12, 1'b0);
      check_idle("sat_up");
    end
    for (int i = 0; i < 7; i++) begin
      single_press(1'b0, 12, 1'b0);
      check_idle("sat_down");
    end
    game_active = 1'b1;
    tick(1);
    repeat (3) single_press(1'b1, 12, 1'b0);
    check_idle("lock");
    game_active = 1'b0;
    tick(12);
    check_idle("lock_release");
    single_press(1'b1, 12, 1'b0);
    check_idle("after_lock");
    both_press(1'b0, 1'b1);
    check_idle("simultaneous");
    both_press(1'b1, 1'b1);
    check_idle("staggered");
    btn_down = 1'b1;
    tick(4);
    rst = 1'b1;
    #1;
    model = RSTC;
    exp_q.delete();
    check("midop_reset_count", int'(COLOR_NUM), RSTC);
    tick(2);
    expect_step(-1);
    rst = 1'b0;
    tick(15);
    btn_down = 1'b0;
    tick(14);
    check_idle("midop_after");
    for (int i = 0; i < 40; i++) begin
      game_active = ($urandom_range(0, 3) == 0);
      tick(1);
      kind = $urandom_range(0, 3);
      if (kind < 2) single_press(kind == 0, $urandom_range(10, 16), 1'($urandom_range(0, 1)));
      else both_press(kind == 3, 1'($urandom_range(0, 1)));
      game_active = 1'b0;
      tick(2);
      check_idle("random");
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
